led_tick_gen: RTL
=================

# led_tick_gen

Rate generator that produces the single-cycle `i_valid` strobe consumed by the LED shift stage directly downstream. It divides `clock` by one of four parameterised limits selected at run time by switches, and supports a run/stop enable. It also offers an optional debounced-free single-step button path for manual advancing while stopped. Output is fully registered and drives the shift stage's `i_valid` with no glue logic.

## Interface

- `NB_COUNTER`, 32, width of the internal period counter
- `LIMIT_0`, 2**22-1, terminal count for speed select 0
- `LIMIT_1`, 2**23-1, terminal count for speed select 1
- `LIMIT_2`, 2**24-1, terminal count for speed select 2
- `LIMIT_3`, 2**25-1, terminal count for speed select 3 (all limits must fit in `NB_COUNTER` bits)

- `clock` input 1 single clock, all state updates on rising edge
- `i_reset` input 1 synchronous, active-high reset
- `i_enable` input 1 run (1) / stop (0)
- `i_speed_sel` input 2 selects LIMIT_0..LIMIT_3, sampled every cycle
- `i_step` input 1 asynchronous push-button, single-step request while stopped
- `o_valid` output 1 one-cycle strobe to downstream shift stage
- `o_count` output NB_COUNTER current counter value (debug/visibility)

## Operation

- Registers: `r_count[NB_COUNTER-1:0]`, `r_valid`, `r_step_sync[1:0]`, `r_step_prev`; `o_valid = r_valid`, `o_count = r_count`.
- `limit` = mux of LIMIT_0..3 by `i_speed_sel`, combinational, re-evaluated each cycle.
- Priority per rising edge: reset > enable-run > step > idle.
- Reset (`i_reset`=1): `r_count`=0, `r_valid`=0, `r_step_sync`=2'b00, `r_step_prev`=0. All outputs 0 the cycle after.
- Run (`i_enable`=1): if `r_count >= limit` then `r_count`<=0, `r_valid`<=1; else `r_count`<=`r_count`+1, `r_valid`<=0.
- `>=` compare (not `==`): a speed change to a limit below the current count wraps on the next edge with one strobe; counter never runs past limit.
- Stop (`i_enable`=0): `r_count`<=0; `r_valid`<=step pulse (see below), else 0.
- Step: `i_step` → 2-flop synchroniser → `r_step_prev`; pulse = `r_step_sync[1] & ~r_step_prev`. Honoured only when `i_enable`=0; ignored (dropped, not queued) while running.
- Synchroniser and `r_step_prev` always clock regardless of `i_enable`, so an edge that occurs while running is consumed, not replayed on stop.
- Counter arithmetic is unsigned, NB_COUNTER wide; no overflow possible given compare.

## Timing

- Run period = limit+1 cycles; `o_valid` high exactly 1 cycle per period.
- From reset release with `i_enable`=1 held: `o_valid` first high after rising edge number limit+1 (counting the first non-reset edge as 1).
- limit = 0: `o_valid` high every cycle while enabled (continuous strobe).
- Enable 1→0: `o_valid` low and `r_count`=0 after the next edge; a strobe already registered that edge is not suppressed.
- Enable 0→1: counting restarts from 0; full period before first strobe.
- Step latency: `i_step` rising (stable before edge 1) → `o_valid` high after edge 3, for exactly 1 cycle; held button yields one pulse only.
- Reset mid-count or mid-step: all state cleared on that edge; pending step lost.

## Configuration

- `LED_TICK_STEP_EN` defined: step path (synchroniser, edge detect, stop-mode strobe) present as above.
- Not defined: `i_step` port remains but is ignored; synchroniser/`r_step_prev` not instantiated; `o_valid` only from run mode, always 0 while stopped.

## Test plan

Bench overrides LIMIT_0..3 = 3, 7, 0, 15.

- Reset held 4 cycles, then `i_enable`=1, sel=0 → `o_valid` first high after edge 4, then every 4 cycles; `o_count` cycles 0,1,2,3.
- sel=1 running, switch to sel=0 when `o_count`=6 → strobe on next edge, `o_count`=0, then period 4.
- sel=2 (limit 0), enable=1 → `o_valid` high every cycle; enable=0 → low after next edge, `o_count`=0.
- Stop mode, `i_step` pulse held 10 cycles (STEP_EN defined) → exactly one `o_valid` pulse 3 edges after rise; `i_step` asserted while running → no extra strobe, none after later stop.
- `i_reset` asserted at `o_count`=10 (sel=3) → next edge `o_count`=0, `o_valid`=0; release → first strobe 16 cycles later.
- Build without `LED_TICK_STEP_EN`: stopped, toggle `i_step` 5 times → `o_valid` stays 0.

Source files
------------

// File: rtl/led_tick_gen.sv
// Rate generator producing a one-cycle o_valid strobe every limit+1 cycles while enabled.
// Optional single-step path while stopped is built only when LED_TICK_STEP_EN is defined.
module led_tick_gen #(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = 2**22 - 1,
  parameter int unsigned LIMIT_1    = 2**23 - 1,
  parameter int unsigned LIMIT_2    = 2**24 - 1,
  parameter int unsigned LIMIT_3    = 2**25 - 1
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_speed_sel,
  input  logic                  i_step,
  output logic                  o_valid,
  output logic [NB_COUNTER-1:0] o_count
);

  localparam logic [NB_COUNTER-1:0] LIM_0 = NB_COUNTER'(LIMIT_0);
  localparam logic [NB_COUNTER-1:0] LIM_1 = NB_COUNTER'(LIMIT_1);
  localparam logic [NB_COUNTER-1:0] LIM_2 = NB_COUNTER'(LIMIT_2);
  localparam logic [NB_COUNTER-1:0] LIM_3 = NB_COUNTER'(LIMIT_3);
  localparam logic [NB_COUNTER-1:0] ONE   = {{(NB_COUNTER-1){1'b0}}, 1'b1};

  logic [NB_COUNTER-1:0] count_q, count_d;
  logic                  valid_q, valid_d;
  logic [NB_COUNTER-1:0] limit;
  logic                  step_pulse;

  always_comb begin
    limit = LIM_0;
    case (i_speed_sel)
      2'd0: limit = LIM_0;
      2'd1: limit = LIM_1;
      2'd2: limit = LIM_2;
      2'd3: limit = LIM_3;
      default: limit = LIM_0;
    endcase
  end

`ifdef LED_TICK_STEP_EN
  logic [1:0] step_sync_q, step_sync_d;
  logic       step_prev_q, step_prev_d;

  // Synchroniser keeps running while enabled so edges seen during run are consumed.
  always_comb begin
    step_sync_d = {step_sync_q[0], i_step};
    step_prev_d = step_sync_q[1];
    step_pulse  = step_sync_q[1] & ~step_prev_q;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
    end
  end
`else
  logic unused_step;
  assign unused_step = i_step;
  assign step_pulse  = 1'b0;
`endif

  // >= rather than == so a switch to a smaller limit wraps immediately.
  always_comb begin
    count_d = count_q;
    valid_d = 1'b0;
    if (i_enable) begin
      if (count_q >= limit) begin
        count_d = '0;
        valid_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = '0;
      valid_d = step_pulse;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_count = count_q;

endmodule
